sram_access_ctrl: RTL and testbench
===================================

Name: sram_access_ctrl

Overview:
Downstream stage of the SPI frame decoder inside main. It accepts one decoded command per handshake: read/write, a 17-bit address and 8 bits of write data. It runs a timed access on the external async SRAM through cen/oen/wen, addr and a bidirectional data bus, then returns a response with read data to the SPI side for shifting out on miso.

Parameters:
ADDR_W, 17, SRAM address width
DATA_W, 8, SRAM data width
SETUP_CYC, 1, cycles with addr/cen valid before strobe; range 1..15
ACCESS_CYC, 3, cycles wen or oen held low; range 1..15
HOLD_CYC, 1, cycles after strobe release with addr/cen/data still held; range 1..15

Ports:
clk  in  1  system clock; all logic on rising edge
rstn  in  1  synchronous reset, active-low
cmd_valid  in  1  command present from SPI decoder
cmd_ready  out  1  controller can accept a command
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  SRAM address
cmd_wdata  in  DATA_W  write data, ignored for reads
rsp_valid  out  1  one-cycle pulse when the access completes (reads and writes)
rsp_rdata  out  DATA_W  captured read data; holds its value until the next read completes
busy  out  1  transaction in progress
cen  out  1  SRAM chip enable, active-low
oen  out  1  SRAM output enable, active-low
wen  out  1  SRAM write enable, active-low
addr  out  ADDR_W  SRAM address bus
data  inout  DATA_W  SRAM data bus; driven only during writes, else high-Z

Behaviour:
- Reset (rstn=0 at posedge clk):
  - cen=oen=wen=1, addr=0, data released (Z).
  - rsp_valid=0, rsp_rdata=0, busy=0, cmd_ready=1 once rstn=1.
- All SRAM-side outputs are registered, with no combinational path from cmd_* to SRAM pins.
- FSM states: IDLE, SETUP, ACCESS, HOLD. A down-counter (4 bits) times each phase.
- Handshake:
  - cmd_ready = (state==IDLE).
  - Accept on the posedge where cmd_valid & cmd_ready. cmd_write/addr/wdata are latched then.
  - While busy, cmd_valid is left pending by upstream and is not accepted.
- Sequence, with the command accepted at the end of cycle N (defaults):
  - IDLE -> SETUP (N+1): cen=0, addr=latched; on a write, data is driven with wdata.
  - SETUP -> ACCESS after SETUP_CYC cycles (N+2..N+4): write: wen=0; read: oen=0.
  - ACCESS -> HOLD after ACCESS_CYC cycles (N+5): wen=1, oen=1; cen, addr and data (write) remain held.
  - HOLD -> IDLE after HOLD_CYC cycles (N+6): cen=1, data released, rsp_valid=1 for exactly this cycle, cmd_ready=1.
- Read capture: data is sampled into rsp_rdata at the posedge ending the last ACCESS cycle, while oen is still low.
- Writes pulse rsp_valid but leave rsp_rdata unchanged.
- Back-to-back commands: cmd_valid high in the rsp_valid cycle is accepted, so the next SETUP is at N+7. Period is 1+SETUP_CYC+ACCESS_CYC+HOLD_CYC cycles (6 with defaults).
- wen and oen are never low in the same cycle.
- data is never driven while oen=0.
- data is driven only when cen=0 and the access is a write.
- Reset mid-operation: the access is abandoned and all outputs go to reset values on that edge, with no rsp_valid. The next command after rstn=1 starts a clean SETUP.
- Simultaneous reset and cmd_valid: reset wins and the command is not accepted.
- addr stays at the last used value in IDLE (no toggling); it is 0 only after reset.
- A parameter value of 0 is illegal and triggers an elaboration-time error.

Test Plan:
- Reset: rstn=0 for 3 cycles, then 1 -> cen=oen=wen=1, data=Z, rsp_valid=0, cmd_ready=1; then assert rstn=0 mid-ACCESS -> outputs return to idle on that edge and rsp_valid never pulses.
- Single write: cmd_write=1, addr=17'h139c6, wdata=8'h9c -> cen low N+1..N+5, wen low exactly N+2..N+4, data=8'h9c from N+1..N+5, rsp_valid at N+6 only, rsp_rdata unchanged.
- Single read: SRAM model returns 8'h9c at 17'h139c6 -> oen low N+2..N+4, data never driven by the DUT, rsp_valid at N+6 with rsp_rdata=8'h9c.
- Back-to-back: write 0x9c to 0x139c6, then read 0x139c6 with cmd_valid held high -> second accept in the rsp_valid cycle, second rsp_valid 6 cycles later with rsp_rdata=8'h9c.
- Busy hold-off: assert cmd_valid during ACCESS -> cmd_ready=0 and no new SETUP until IDLE; the command is accepted on the first IDLE cycle.
- Parameter sweep SETUP_CYC=2, ACCESS_CYC=5, HOLD_CYC=3 -> strobe low for exactly 5 cycles, rsp_valid 11 cycles after accept, wen/oen never both low.

Source files
------------

// File: rtl/sram_access_ctrl.sv
// SRAM access controller: runs one timed async-SRAM read or write per
// accepted command and reports completion with a one-cycle response pulse.
module sram_access_ctrl #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int ACCESS_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              cen,
    output logic              oen,
    output logic              wen,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data
);

    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
        $error("SETUP_CYC must be in 1..15");
    end
    if (ACCESS_CYC < 1 || ACCESS_CYC > 15) begin : g_bad_access
        $error("ACCESS_CYC must be in 1..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $error("HOLD_CYC must be in 1..15");
    end

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] ACCESS_LD = 4'(ACCESS_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              wr_q;
    logic              drive;
    logic [DATA_W-1:0] wdata_q;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign data      = drive ? wdata_q : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wr_q      <= 1'b0;
            drive     <= 1'b0;
            wdata_q   <= '0;
            cen       <= 1'b1;
            oen       <= 1'b1;
            wen       <= 1'b1;
            addr      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state   <= SETUP;
                        cnt     <= SETUP_LD;
                        cen     <= 1'b0;
                        addr    <= cmd_addr;
                        wr_q    <= cmd_write;
                        wdata_q <= cmd_wdata;
                        drive   <= cmd_write;
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        state <= ACCESS;
                        cnt   <= ACCESS_LD;
                        wen   <= ~wr_q;
                        oen   <= wr_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state <= HOLD;
                        cnt   <= HOLD_LD;
                        wen   <= 1'b1;
                        oen   <= 1'b1;
                        // oen is still low on this edge, so the bus is valid
                        if (!wr_q) begin
                            rsp_rdata <= data;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 4'd0) begin
                        state     <= IDLE;
                        cen       <= 1'b1;
                        drive     <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench for sram_access_ctrl: default timing and a 2/5/3 sweep,
// each with its own SRAM model, stimulus stream and cycle-timeline monitor.
module tb_sram_access_ctrl;

    logic clk;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   done [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int g,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d got %h want %h at %0t",
                     nm, g, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input logic [16:0] a);
        return a[7:0] ^ 8'h5a;
    endfunction

    // An undriven bus reads as z on 4-state simulators and 0 on 2-state ones
    function automatic bit released(input logic [7:0] d);
        return (d === 8'hzz) || (d === 8'h00);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int S = (g == 0) ? 1 : 2;
        localparam int A = (g == 0) ? 3 : 5;
        localparam int H = (g == 0) ? 1 : 3;
        localparam int L = S + A + H;

        logic        rstn, cmd_valid, cmd_ready, cmd_write;
        logic [16:0] cmd_addr;
        logic [7:0]  cmd_wdata;
        logic        rsp_valid, busy, cen, oen, wen;
        logic [7:0]  rsp_rdata;
        logic [16:0] addr;
        wire  [7:0]  data;

        sram_access_ctrl #(
            .ADDR_W(17), .DATA_W(8),
            .SETUP_CYC(S), .ACCESS_CYC(A), .HOLD_CYC(H)
        ) dut (
            .clk(clk), .rstn(rstn),
            .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
            .cmd_write(cmd_write), .cmd_addr(cmd_addr),
            .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
            .rsp_rdata(rsp_rdata), .busy(busy),
            .cen(cen), .oen(oen), .wen(wen),
            .addr(addr), .data(data)
        );

        // Async SRAM model
        logic [7:0] mem [int];
        logic [7:0] rd_val = 8'h00;
        assign data = (cen === 1'b0 && oen === 1'b0) ? rd_val : 8'hzz;
        always @(negedge oen)
            rd_val = mem.exists(int'(addr)) ? mem[int'(addr)] : init_val(addr);
        always @(posedge wen)
            if (cen === 1'b0) mem[int'(addr)] = data;

        // Reference model and scoreboard
        logic [7:0] ref_mem [int];
        logic [7:0] last_rd;
        logic [7:0] sb [$];

        function automatic logic [7:0] ref_rd(input logic [16:0] a);
            return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
        endfunction

        task automatic wait_ready(output bit ok);
            ok = 1'b0;
            for (int i = 0; i < 64 && !ok; i++) begin
                @(negedge clk);
                ok = cmd_ready;
            end
            chk("accept", g, 32'(ok), 32'd1);
        endtask

        task automatic issue(input bit w, input logic [16:0] a,
                             input logic [7:0] d);
            bit ok;
            cmd_valid = 1'b1;
            cmd_write = w;
            cmd_addr  = a;
            cmd_wdata = d;
            if (w) ref_mem[int'(a)] = d;
            else   last_rd = ref_rd(a);
            sb.push_back(last_rd);
            wait_ready(ok);
            @(posedge clk);
            #1 cmd_valid = 1'b0;
        endtask

        task automatic drain();
            for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
            chk("drain", g, 32'(sb.size()), 32'd0);
            #1;
        endtask

        // Stimulus
        initial begin
            bit ok;
            rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
            cmd_addr = '0; cmd_wdata = '0; last_rd = 8'h00;
            repeat (3) @(posedge clk);
            #1 rstn = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            issue(1'b1, 17'h139c6, 8'h9c);
            repeat (3) @(posedge clk);
            #1;
            issue(1'b0, 17'h139c6, 8'h00);
            repeat (2) @(posedge clk);
            #1;
            issue(1'b1, 17'h139c6, 8'h9c);
            issue(1'b0, 17'h139c6, 8'h00);
            for (int n = 0; n < 40; n++) begin
                int gap;
                issue(1'($urandom), 17'h139c0 + 17'($urandom_range(0, 7)),
                      8'($urandom));
                gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 8);
                repeat (gap) @(posedge clk);
                if (gap != 0) #1;
            end
            drain();
            repeat (3) @(posedge clk);
            #1;
            // Abandon a read one cycle into its strobe
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 17'h139c6;
            wait_ready(ok);
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            repeat (S) @(posedge clk);
            #1 rstn = 1'b0;
            @(posedge clk);
            #1 rstn = 1'b1;
            last_rd = 8'h00;
            repeat (2) @(posedge clk);
            #1;
            issue(1'b1, 17'h139c1, 8'ha5);
            issue(1'b0, 17'h139c1, 8'h00);
            issue(1'b0, 17'h139c6, 8'h00);
            drain();
            repeat (4) @(posedge clk);
            done[g] = 1'b1;
        end

        // Monitor: expected pin behaviour as a timeline from the accept cycle
        initial begin
            int          cyc = 0, acc_cyc = 0, k;
            bit          started = 0, rst_pend = 0, active = 0;
            bit          act, stb, rsp, acc_w;
            logic [16:0] acc_addr = '0, a_exp = '0;
            logic [7:0]  acc_wd = '0;
            forever begin
                @(negedge clk);
                if (rst_pend) begin
                    active = 0;
                    a_exp  = '0;
                end
                if (started) begin
                    k   = cyc - acc_cyc;
                    act = active && k >= 1 && k <= L;
                    stb = active && k >= S + 1 && k <= S + A;
                    rsp = active && k == L + 1;
                    if (act) a_exp = acc_addr;
                    chk("ctrl{cen,oen,wen,rsp,rdy,busy}", g,
                        32'({cen, oen, wen, rsp_valid, cmd_ready, busy}),
                        32'({!act, !(stb && !acc_w), !(stb && acc_w),
                             rsp, !act, act}));
                    chk("addr", g, 32'(addr), 32'(a_exp));
                    chk("wen_oen_excl", g, 32'(!(wen === 1'b0 && oen === 1'b0)), 32'd1);
                    if (act && acc_w)
                        chk("wdata_bus", g, 32'(data), 32'(acc_wd));
                    else if (!stb)
                        chk("bus_released", g, 32'(released(data)), 32'd1);
                    if (rst_pend)
                        chk("rdata_reset", g, 32'(rsp_rdata), 32'd0);
                    if (rsp_valid === 1'b1) begin
                        if (sb.size() == 0)
                            chk("sb_underflow", g, 32'(sb.size()), 32'd1);
                        else
                            chk("rsp_rdata", g, 32'(rsp_rdata), 32'(sb.pop_front()));
                    end
                    if (rsp) active = 0;
                    if (rstn && cmd_valid && !act) begin
                        active   = 1;
                        acc_cyc  = cyc;
                        acc_w    = cmd_write;
                        acc_addr = cmd_addr;
                        acc_wd   = cmd_wdata;
                    end
                end
                rst_pend = !rstn;
                if (!rstn) started = 1;
                cyc++;
            end
        end
    end

    initial begin
        bit fin = 0;
        for (int i = 0; i < 30000 && !fin; i++) begin
            @(posedge clk);
            fin = done[0] && done[1];
        end
        chk("finish_timeout", 0, 32'(fin), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
